// File: rtl/scan_pkg.sv
// Shared definitions for the 8-line scan controller: line count and FSM state encoding.
package scan_pkg;

  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational search for the next enabled line above idx, wrapping past 7.
// wrap is set whenever the search passes line 7, including the single-line case.
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [2:0]           idx,
  input  logic [NUM_LINES-1:0] mask,
  output logic [2:0]           nxt_idx,
  output logic                 wrap
);

  logic [NUM_LINES-1:0] rot;
  logic [2:0]           ofs;
  logic [3:0]           sum;

  // rot[k] is the enable of line idx+k+1 (mod 8), so the lowest set bit is the next line.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_rot
      localparam logic [2:0] STEP = 3'((gi + 1) % NUM_LINES);
      assign rot[gi] = mask[idx + STEP];
    end
  endgenerate

  always_comb begin
    ofs = 3'd0;
    for (int k = NUM_LINES - 1; k >= 0; k--) begin
      if (rot[k]) ofs = 3'(k);
    end
  end

  assign sum     = {1'b0, idx} + {1'b0, ofs} + 4'd1;
  assign nxt_idx = (mask == '0) ? idx : sum[2:0];
  assign wrap    = (mask != '0) && sum[3];

endmodule

// File: rtl/scan_ctrl8.sv
// Time-multiplexed one-hot scan of 8 lines with a blanking gap at the start of each slot.
module scan_ctrl8
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int BLANK   = 100,
  parameter int DIV_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_opt,
  input  logic [7:0]  i_mask,
  input  logic [31:0] i_data,
  output logic [7:0]  o_sel,
  output logic [2:0]  o_idx,
  output logic [3:0]  o_nib,
  output logic        o_frame
);

  localparam logic [DIV_W-1:0] LAST_CNT   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] ON_START   = DIV_W'(BLANK);
  localparam state_t           SLOT_START = (BLANK == 0) ? ST_ON : ST_BLANK;

  state_t           state_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic             frame_reg;

  logic [2:0]       search_idx;
  logic [2:0]       nxt_idx;
  logic             nxt_wrap;
  logic [DIV_W-1:0] cnt_next;
  logic [7:0]       sel_act;

  // Searching from line 7 yields the lowest enabled line, with wrap set, for the IDLE exit.
  assign search_idx = (state_reg == ST_IDLE) ? 3'd7 : idx_reg;
  assign cnt_next   = cnt_reg + DIV_W'(1);

  scan_next_idx u_next_idx (
    .idx     (search_idx),
    .mask    (i_mask),
    .nxt_idx (nxt_idx),
    .wrap    (nxt_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      frame_reg <= 1'b0;
    end else if (!i_en || i_mask == '0) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      frame_reg <= 1'b0;
    end else if (state_reg == ST_IDLE || cnt_reg == LAST_CNT) begin
      state_reg <= SLOT_START;
      cnt_reg   <= '0;
      idx_reg   <= nxt_idx;
      frame_reg <= nxt_wrap;
    end else begin
      state_reg <= (cnt_next >= ON_START) ? ST_ON : ST_BLANK;
      cnt_reg   <= cnt_next;
      frame_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_sel
      assign sel_act[gi] = (state_reg == ST_ON) && (idx_reg == 3'(gi));
    end
  endgenerate

  // Active-high one-hot, flipped to active-low when i_opt=0.
  assign o_sel   = sel_act ^ {8{~i_opt}};
  assign o_idx   = idx_reg;
  assign o_frame = frame_reg;
  assign o_nib   = i_data[{idx_reg, 2'b00} +: 4];

endmodule

// File: tb/tb_scan_ctrl8.sv
// Self-checking bench for scan_ctrl8: slot-position reference model plus directed literal checks.
module tb_scan_ctrl8;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en    = 1'b0;
  logic        i_opt   = 1'b0;
  logic [7:0]  i_mask  = 8'hFF;
  logic [31:0] i_data  = 32'h76543210;
  logic [7:0]  o_sel;
  logic [2:0]  o_idx;
  logic [3:0]  o_nib;
  logic        o_frame;

  int checks = 0;
  int errors = 0;

  // Reference: is a scan running, how far into the slot, which line, frame pulse.
  bit m_run;
  int m_pos;
  int m_idx;
  bit m_frame;

  always #5 i_clk = ~i_clk;

  scan_ctrl8 #(.CLK_DIV(CLK_DIV), .BLANK(BLANK), .DIV_W(16)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_opt   (i_opt),
    .i_mask  (i_mask),
    .i_data  (i_data),
    .o_sel   (o_sel),
    .o_idx   (o_idx),
    .o_nib   (o_nib),
    .o_frame (o_frame)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int next_line(input int cur, input logic [7:0] mask);
    for (int k = 1; k <= 8; k++) begin
      if (mask[(cur + k) % 8]) return (cur + k) % 8;
    end
    return cur;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_run = 0; m_pos = 0; m_idx = 0; m_frame = 0;
    end else if (!i_en || i_mask == 8'h00) begin
      m_run = 0; m_pos = 0; m_frame = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_idx = next_line(7, i_mask); m_frame = 1;
    end else if (m_pos == CLK_DIV - 1) begin
      int nx;
      nx = next_line(m_idx, i_mask);
      m_frame = (nx <= m_idx);
      m_idx = nx;
      m_pos = 0;
    end else begin
      m_pos++;
      m_frame = 0;
    end
  end

  always @(negedge i_clk) begin : cmp
    logic [7:0] act;
    if (i_rst_n) begin
      act = (m_run && m_pos >= BLANK) ? (8'b1 << m_idx) : 8'h00;
      chk("sel", 32'(o_sel), 32'(act ^ {8{~i_opt}}));
      chk("idx", 32'(o_idx), 32'(m_idx));
      chk("nib", 32'(o_nib), 32'(i_data[m_idx*4 +: 4]));
      chk("frame", 32'(o_frame), 32'(m_frame));
    end
  end

  task automatic samp();
    @(negedge i_clk);
    #1;
  endtask

  initial begin
    logic [7:0] sv [16];
    logic [2:0] iv [16];
    logic       fv [16];
    logic [7:0] exp1 [8];
    logic [7:0] sel7;
    int n;

    exp1 = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};

    #1;
    chk("rst_sel", 32'(o_sel), 32'hFF);
    chk("rst_idx", 32'(o_idx), 32'd0);
    chk("rst_frame", 32'(o_frame), 32'd0);
    chk("rst_nib", 32'(o_nib), 32'h0);

    // Full mask, active-low.
    #21 i_rst_n = 1'b1; i_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      samp(); sv[i] = o_sel; fv[i] = o_frame;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("full_sel%0d", i), 32'(sv[i]), 32'(exp1[i]));
    chk("full_frame0", 32'(fv[0]), 32'd1);
    n = 0; sel7 = 8'h00;
    do begin
      samp(); n++;
      if (n == 22) sel7 = o_sel;
    end while (!o_frame && n < 100);
    chk("frame_period", 32'(n + 7), 32'd32);
    chk("line7_sel", 32'(sel7), 32'h7F);
    chk("wrap_idx", 32'(o_idx), 32'd0);
    $display("scenario full-mask: period %0d cycles", n + 7);

    // Two lines, active-high.
    i_en = 1'b0;
    samp();
    chk("idle_sel", 32'(o_sel), 32'hFF);
    i_mask = 8'b0010_0100; i_opt = 1'b1; i_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      samp(); sv[i] = o_sel; iv[i] = o_idx; fv[i] = o_frame;
    end
    chk("two_idx0", 32'(iv[0]), 32'd2);
    chk("two_idx4", 32'(iv[4]), 32'd5);
    chk("two_idx8", 32'(iv[8]), 32'd2);
    chk("two_idx12", 32'(iv[12]), 32'd5);
    chk("two_frame0", 32'(fv[0]), 32'd1);
    chk("two_frame4", 32'(fv[4]), 32'd0);
    chk("two_frame8", 32'(fv[8]), 32'd1);
    chk("two_sel0", 32'(sv[0]), 32'h00);
    chk("two_sel1", 32'(sv[1]), 32'h04);
    chk("two_sel5", 32'(sv[5]), 32'h20);
    $display("scenario two-line: idx %0d %0d %0d %0d", iv[0], iv[4], iv[8], iv[12]);

    // Single line.
    i_en = 1'b0;
    samp();
    i_mask = 8'h08; i_opt = 1'b0; i_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      samp(); sv[i] = o_sel; iv[i] = o_idx; fv[i] = o_frame;
    end
    chk("one_sel0", 32'(sv[0]), 32'hFF);
    chk("one_sel2", 32'(sv[2]), 32'hF7);
    chk("one_sel4", 32'(sv[4]), 32'hFF);
    chk("one_frame2", 32'(fv[2]), 32'd0);
    chk("one_frame4", 32'(fv[4]), 32'd1);
    chk("one_idx4", 32'(iv[4]), 32'd3);
    $display("scenario single-line: done");

    // Enable drop during ON at line 4, restart with upper mask.
    i_en = 1'b0;
    samp();
    i_mask = 8'hFF; i_en = 1'b1;
    repeat (18) samp();
    chk("en_on_idx", 32'(o_idx), 32'd4);
    chk("en_on_sel", 32'(o_sel), 32'hEF);
    i_en = 1'b0;
    samp();
    chk("en_off_sel", 32'(o_sel), 32'hFF);
    chk("en_off_idx", 32'(o_idx), 32'd4);
    i_mask = 8'hF0; i_en = 1'b1;
    samp();
    chk("en_re_idx", 32'(o_idx), 32'd4);
    chk("en_re_frame", 32'(o_frame), 32'd1);
    $display("scenario enable-drop: done");

    // Mask cleared mid-slot, then asynchronous reset mid-ON.
    samp(); samp();
    chk("mask_on_sel", 32'(o_sel), 32'hEF);
    i_mask = 8'h00;
    samp();
    chk("mask0_sel", 32'(o_sel), 32'hFF);
    i_mask = 8'hFF;
    repeat (6) samp();
    chk("pre_rst_sel", 32'(o_sel), 32'hFD);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(o_sel), 32'hFF);
    chk("arst_idx", 32'(o_idx), 32'd0);
    chk("arst_frame", 32'(o_frame), 32'd0);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    $display("scenario reset: done");

    // Polarity and data follow inputs combinationally.
    samp(); samp();
    chk("pol_pre", 32'(o_sel), 32'hFE);
    i_opt = 1'b1;
    #1 chk("pol_flip", 32'(o_sel), 32'h01);
    i_data = 32'hFEDCBA98;
    #1 chk("nib_live", 32'(o_nib), 32'h8);
    i_opt = 1'b0; i_data = 32'h76543210;
    $display("scenario polarity: done");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      samp();
      if ($urandom_range(0, 29) == 0)
        i_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 39) == 0) i_en = ~i_en;
      if ($urandom_range(0, 19) == 0) i_opt = ~i_opt;
      if ($urandom_range(0, 4) == 0) i_data = $urandom;
    end
    $display("scenario random: 3000 cycles");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
